// File: rtl/gaplus_share_arb.sv
// gaplus_share_arb
//
// Two-port arbiter/sequencer for the Gaplus main/sub CPU shared work RAM.
// Each access is a three-state transaction: IDLE (arbitrate, capture the
// winner's request), ADDR (drive address/data/strobe to the RAM), DATA (RAM
// read data valid, result latched). The ack is registered high in the cycle
// after DATA, which is again IDLE. Round-robin between the two ports on
// contention, port 0 winning the first contention after reset.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/req1             access requests (held until the matching ack)
//   ad0/ad1, wd0/wd1      request address / write data
//   we0/we1               1 = write, 0 = read
//   ack0/ack1             one-cycle completion pulses
//   rd0/rd1               latched read data per port
//   wait0/wait1           CPU stall (request pending, not yet acked)
//   mem_ad/mem_wd/mem_we  shared-memory address, write data, write strobe
//   mem_rd                shared-memory read data (one cycle after address)
//   sel                   bus owner: 1 = port 0, 0 = port 1
//   busy                  high while a transaction is in ADDR or DATA
module gaplus_share_arb #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] ad0,
    input  logic [AW-1:0] ad1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    input  logic          we0,
    input  logic          we1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          wait0,
    output logic          wait1,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          sel,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;       // port granted most recently (1 = port 1)
    logic [AW-1:0] ad_q;
    logic [DW-1:0] wd_q;
    logic          we_q;
    logic          elig0;
    logic          elig1;
    logic          start;
    logic          grant0;

    // A port whose ack is showing this cycle has just been served; its
    // request is still high only because the CPU has not yet seen the ack.
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        grant0    = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                    // Port 0 wins when alone, or on contention if port 1
                    // was the previous owner.
                    grant0    = elig0 & (~elig1 | last);
                end
            end
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture: owner, request snapshot and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel  <= 1'b1;
            last <= 1'b1;
            ad_q <= '0;
            wd_q <= '0;
            we_q <= 1'b0;
        end else if (start) begin
            sel  <= grant0;
            last <= ~grant0;
            ad_q <= grant0 ? ad0 : ad1;
            wd_q <= grant0 ? wd0 : wd1;
            we_q <= grant0 ? we0 : we1;
        end
    end

    // Completion: ack pulse and read-data capture at the end of DATA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            rd0  <= '0;
            rd1  <= '0;
        end else begin
            ack0 <= (state == DATA) &  sel;
            ack1 <= (state == DATA) & ~sel;
            if ((state == DATA) && !we_q) begin
                if (sel) begin
                    rd0 <= mem_rd;
                end else begin
                    rd1 <= mem_rd;
                end
            end
        end
    end

    // Address/data stay parked on the last transaction while idle; the
    // strobe is qualified by state so an async reset kills it at once.
    assign mem_ad = ad_q;
    assign mem_wd = wd_q;
    assign mem_we = (state == ADDR) & we_q;
    assign busy   = (state != IDLE);
    assign wait0  = req0 & ~ack0;
    assign wait1  = req1 & ~ack1;

endmodule
